// File: rtl/gestor_carga_baterias.sv
// Two-battery charge manager: discharges the active battery under load, recharges
// each battery from its own charger, and switches batteries automatically when one empties.
module gestor_carga_baterias #(
  parameter int PASO_DESCARGA = 8,
  parameter int PASO_CARGA    = 16,
  parameter int CARGA_INICIAL = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       consumo,
  input  logic       cargador_1,
  input  logic       cargador_2,
  output logic [3:0] carga_bateria1,
  output logic [3:0] carga_bateria2,
  output logic       bateria_activa,
  output logic       sin_energia,
  output logic       cambio
);

  localparam int WD = (PASO_DESCARGA > 2) ? $clog2(PASO_DESCARGA) : 1;
  localparam int WC = (PASO_CARGA > 2) ? $clog2(PASO_CARGA) : 1;
  localparam logic [WD-1:0] ULTIMO_DES = WD'(PASO_DESCARGA - 1);
  localparam logic [WC-1:0] ULTIMO_CAR = WC'(PASO_CARGA - 1);
  localparam logic [3:0]    INICIAL    = 4'(CARGA_INICIAL);

  localparam logic [1:0] USAR_B1  = 2'd0;
  localparam logic [1:0] USAR_B2  = 2'd1;
  localparam logic [1:0] AGOTADAS = 2'd2;

  logic [1:0]    r_state;
  logic [WD-1:0] r_pre_des;
  logic [WC-1:0] r_pre_c1;
  logic [WC-1:0] r_pre_c2;
  logic [3:0]    r_c1;
  logic [3:0]    r_c2;
  logic          r_activa;
  logic          r_sin;
  logic          r_cambio;

  logic [1:0] w_state_next;
  logic       w_activa_next;
  logic       w_cambio_estado;
  logic       w_paso_des;
  logic       w_des1;
  logic       w_des2;
  logic       w_car1;
  logic       w_car2;

  // Simultaneous charge and discharge cancel out; otherwise saturate at 0 and 15.
  function automatic logic [3:0] f_nueva(input logic [3:0] old, input logic des, input logic car);
    if (car && !des && old != 4'd15)
      return old + 4'd1;
    else if (des && !car && old != 4'd0)
      return old - 4'd1;
    else
      return old;
  endfunction

  // FSM reacts to registered charges, so it lags a battery emptying by one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      USAR_B1:  if (r_c1 == 4'd0) w_state_next = (r_c2 != 4'd0) ? USAR_B2 : AGOTADAS;
      USAR_B2:  if (r_c2 == 4'd0) w_state_next = (r_c1 != 4'd0) ? USAR_B1 : AGOTADAS;
      AGOTADAS: begin
        if (r_c1 != 4'd0)      w_state_next = USAR_B1;
        else if (r_c2 != 4'd0) w_state_next = USAR_B2;
      end
      default:  w_state_next = USAR_B1;
    endcase
  end

  assign w_activa_next   = (w_state_next == USAR_B2) ? 1'b1 :
                           (w_state_next == USAR_B1) ? 1'b0 : r_activa;
  assign w_cambio_estado = (w_state_next != r_state);
  assign w_paso_des      = consumo && (r_state != AGOTADAS) && (r_pre_des == ULTIMO_DES);
  assign w_des1          = w_paso_des && (r_state == USAR_B1);
  assign w_des2          = w_paso_des && (r_state == USAR_B2);
  assign w_car1          = cargador_1 && (r_pre_c1 == ULTIMO_CAR);
  assign w_car2          = cargador_2 && (r_pre_c2 == ULTIMO_CAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= USAR_B1;
      r_pre_des <= '0;
      r_pre_c1  <= '0;
      r_pre_c2  <= '0;
      r_c1      <= INICIAL;
      r_c2      <= INICIAL;
      r_activa  <= 1'b0;
      r_sin     <= 1'b0;
      r_cambio  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_activa <= w_activa_next;
      r_sin    <= (w_state_next == AGOTADAS);
      r_cambio <= (w_activa_next != r_activa);
      r_c1     <= f_nueva(r_c1, w_des1, w_car1);
      r_c2     <= f_nueva(r_c2, w_des2, w_car2);

      // Partial discharge count is lost whenever the load drops or the battery changes.
      if (!consumo || w_cambio_estado)
        r_pre_des <= '0;
      else if (r_state != AGOTADAS)
        r_pre_des <= (r_pre_des == ULTIMO_DES) ? '0 : r_pre_des + 1'b1;

      if (!cargador_1)
        r_pre_c1 <= '0;
      else
        r_pre_c1 <= (r_pre_c1 == ULTIMO_CAR) ? '0 : r_pre_c1 + 1'b1;

      if (!cargador_2)
        r_pre_c2 <= '0;
      else
        r_pre_c2 <= (r_pre_c2 == ULTIMO_CAR) ? '0 : r_pre_c2 + 1'b1;
    end
  end

  assign carga_bateria1 = r_c1;
  assign carga_bateria2 = r_c2;
  assign bateria_activa = r_activa;
  assign sin_energia    = r_sin;
  assign cambio         = r_cambio;

endmodule
